// File: rtl/solver.sv
// Nonogram line-elimination engine: filters each line's candidate options against the
// deduced cells, tells the FIFO which to re-queue, and folds survivors into known/assigned.
module solver #(
   parameter int SIZE = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       started,
   input  logic [SIZE-1:0]            option,
   input  logic [3:0]                 num_rows,
   input  logic [3:0]                 num_cols,
   input  logic                       valid_op,
   input  logic [2*SIZE-1:0][6:0]     old_options_amnt,
   output logic                       put_back_to_FIFO,
   output logic [SIZE-1:0][SIZE-1:0]  assigned,
   output logic [SIZE-1:0][SIZE-1:0]  known,
   output logic                       solved
);

   typedef enum logic [1:0] {S_IDLE, S_LINE, S_OPTS} state_t;

   state_t                    r_state;
   logic [2*SIZE-1:0][6:0]    r_count;
   logic [SIZE-1:0]           r_cur_line;
   logic [6:0]                r_remaining;
   logic [6:0]                r_new_cnt;
   logic [SIZE-1:0]           r_and_acc;
   logic [SIZE-1:0]           r_or_acc;
   logic                      r_seen_ok;
   logic                      r_pass_one;
   logic [SIZE-1:0][SIZE-1:0] r_known;
   logic [SIZE-1:0][SIZE-1:0] r_assigned;
   logic                      r_solved;

   int                        w_line;
   int                        w_nr;
   int                        w_len;
   int                        w_opt_idx;
   logic                      w_is_row;
   logic [SIZE-1:0][SIZE-1:0][SIZE-1:0] w_hit;
   logic [SIZE-1:0]           w_line_known;
   logic [SIZE-1:0]           w_line_assigned;
   logic                      w_consistent;
   logic [SIZE-1:0]           w_and_next;
   logic [SIZE-1:0]           w_or_next;
   logic                      w_seen_next;
   logic [6:0]                w_new_cnt_next;
   logic [6:0]                w_idx_cnt;
   logic                      w_all_known;
   logic [SIZE-1:0][SIZE-1:0] w_known_upd;
   logic [SIZE-1:0][SIZE-1:0] w_assigned_upd;

   // w_hit[r][c][b]: cell (r,c) belongs to the current line and maps to option bit b (MSB = cell 0).
   always_comb begin
      w_line   = int'(r_cur_line);
      w_nr     = int'(num_rows);
      w_is_row = (w_line < w_nr);
      w_len    = w_is_row ? int'(num_cols) : w_nr;
      w_hit           = '0;
      w_line_known    = '0;
      w_line_assigned = '0;
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            for (int b = 0; b < SIZE; b++) begin
               if ((w_is_row && w_line == r && b == w_len - 1 - c) ||
                   (!w_is_row && w_line - w_nr == c && b == w_len - 1 - r)) begin
                  w_hit[r][c][b]     = 1'b1;
                  w_line_known[b]    = r_known[r][c];
                  w_line_assigned[b] = r_assigned[r][c];
               end
            end
         end
      end
   end

   assign w_consistent   = (((option ^ w_line_assigned) & w_line_known) == '0);
   assign w_and_next     = w_consistent ? (r_and_acc & option) : r_and_acc;
   assign w_or_next      = w_consistent ? (r_or_acc | option) : r_or_acc;
   assign w_seen_next    = r_seen_ok | w_consistent;
   assign w_new_cnt_next = r_new_cnt + {6'd0, w_consistent};

   assign put_back_to_FIFO = (r_state == S_OPTS) && valid_op && w_consistent && !r_pass_one;

   // Cells forced by every surviving option: all-1 via AND, all-0 via OR.
   always_comb begin
      w_known_upd    = r_known;
      w_assigned_upd = r_assigned;
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            for (int b = 0; b < SIZE; b++) begin
               if (w_seen_next && w_hit[r][c][b]) begin
                  if (w_and_next[b]) begin
                     w_known_upd[r][c]    = 1'b1;
                     w_assigned_upd[r][c] = 1'b1;
                  end else if (!w_or_next[b]) begin
                     w_known_upd[r][c]    = 1'b1;
                     w_assigned_upd[r][c] = 1'b0;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      w_opt_idx = int'(option);
      w_idx_cnt = '0;
      for (int k = 0; k < 2*SIZE; k++) begin
         if (k == w_opt_idx) begin
            w_idx_cnt = started ? old_options_amnt[k] : r_count[k];
         end
      end
      w_all_known = 1'b1;
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            if (r < w_nr && c < int'(num_cols) && !r_known[r][c]) begin
               w_all_known = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_cur_line  <= '0;
         r_remaining <= '0;
         r_new_cnt   <= '0;
         r_and_acc   <= '1;
         r_or_acc    <= '0;
         r_seen_ok   <= 1'b0;
         r_pass_one  <= 1'b0;
         r_known     <= '0;
         r_assigned  <= '0;
         r_solved    <= 1'b0;
      end else if (valid_op && started) begin
         // The start word doubles as the first line index.
         r_count     <= old_options_amnt;
         r_known     <= '0;
         r_assigned  <= '0;
         r_solved    <= 1'b0;
         r_cur_line  <= option;
         r_remaining <= w_idx_cnt;
         r_and_acc   <= '1;
         r_or_acc    <= '0;
         r_new_cnt   <= '0;
         r_seen_ok   <= 1'b0;
         r_pass_one  <= (w_idx_cnt == 7'd1);
         r_state     <= (w_idx_cnt == 7'd0) ? S_LINE : S_OPTS;
      end else begin
         if (valid_op) begin
            case (r_state)
               S_LINE: begin
                  r_cur_line  <= option;
                  r_remaining <= w_idx_cnt;
                  r_and_acc   <= '1;
                  r_or_acc    <= '0;
                  r_new_cnt   <= '0;
                  r_seen_ok   <= 1'b0;
                  r_pass_one  <= (w_idx_cnt == 7'd1);
                  r_state     <= (w_idx_cnt == 7'd0) ? S_LINE : S_OPTS;
               end
               S_OPTS: begin
                  r_and_acc   <= w_and_next;
                  r_or_acc    <= w_or_next;
                  r_seen_ok   <= w_seen_next;
                  r_new_cnt   <= w_new_cnt_next;
                  r_remaining <= r_remaining - 7'd1;
                  if (r_remaining == 7'd1) begin
                     r_known    <= w_known_upd;
                     r_assigned <= w_assigned_upd;
                     for (int k = 0; k < 2*SIZE; k++) begin
                        if (k == w_line) begin
                           r_count[k] <= r_pass_one ? 7'd0 : w_new_cnt_next;
                        end
                     end
                     r_state <= S_LINE;
                  end
               end
               default: ;
            endcase
         end
         if (r_state != S_IDLE && w_all_known) begin
            r_solved <= 1'b1;
         end
      end
   end

   assign known    = r_known;
   assign assigned = r_assigned;
   assign solved   = r_solved;

endmodule

// File: tb/tb_solver.sv
// Directed bench for solver on the 3x3 board 110/010/101 (assigned packed as {row2,row1,row0}, col0 = LSB).
module tb_solver;

   localparam int SIZE = 3;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       started;
   logic [SIZE-1:0]            option;
   logic [3:0]                 num_rows;
   logic [3:0]                 num_cols;
   logic                       valid_op;
   logic [2*SIZE-1:0][6:0]     old_options_amnt;
   logic                       put_back_to_FIFO;
   logic [SIZE-1:0][SIZE-1:0]  assigned;
   logic [SIZE-1:0][SIZE-1:0]  known;
   logic                       solved;

   int checks = 0;
   int errors = 0;

   solver #(.SIZE(SIZE)) dut (
      .clk              (clk),
      .rst              (rst),
      .started          (started),
      .option           (option),
      .num_rows         (num_rows),
      .num_cols         (num_cols),
      .valid_op         (valid_op),
      .old_options_amnt (old_options_amnt),
      .put_back_to_FIFO (put_back_to_FIFO),
      .assigned         (assigned),
      .known            (known),
      .solved           (solved)
   );

   always #5 clk = ~clk;

   task automatic put_word(input logic s, input logic [SIZE-1:0] w);
      @(negedge clk);
      started  = s;
      option   = w;
      valid_op = 1'b1;
      #1;
      $display("word started=%0d option=%b put_back=%0d", s, w, put_back_to_FIFO);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      started  = 1'b0;
      valid_op = 1'b0;
      option   = '0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      started = 1'b0; valid_op = 1'b0; option = '0;
      num_rows = 4'd3; num_cols = 4'd3;
      old_options_amnt = {7'd3, 7'd2, 7'd1, 7'd1, 7'd3, 7'd2};
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (known !== 9'd0 || assigned !== 9'd0 || solved !== 1'b0 || put_back_to_FIFO !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: known=%b assigned=%b solved=%b pb=%b, want all 0", known, assigned, solved, put_back_to_FIFO);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_pass1_rows();
      put_word(1'b1, 3'd0);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL r0_index_pb: got %b want 0", put_back_to_FIFO); end
      put_word(1'b0, 3'b110);
      checks++;
      if (put_back_to_FIFO !== 1'b1) begin errors++; $display("FAIL r0_110_pb: got %b want 1", put_back_to_FIFO); end
      put_word(1'b0, 3'b011);
      checks++;
      if (put_back_to_FIFO !== 1'b1) begin errors++; $display("FAIL r0_011_pb: got %b want 1", put_back_to_FIFO); end
      idle_cycle();
      checks++;
      if (known !== 9'b000_000_010 || assigned !== 9'b000_000_010) begin
         errors++; $display("FAIL r0_finalize: known=%b assigned=%b want 000000010/000000010", known, assigned);
      end
      put_word(1'b0, 3'd2);
      put_word(1'b0, 3'b101);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL r2_101_pb: got %b want 0", put_back_to_FIFO); end
      idle_cycle();
      checks++;
      if (known !== 9'b111_000_010 || assigned !== 9'b101_000_010) begin
         errors++; $display("FAIL r2_finalize: known=%b assigned=%b want 111000010/101000010", known, assigned);
      end
   endtask

   task automatic test_pass1_cols();
      put_word(1'b0, 3'd3);
      put_word(1'b0, 3'b101);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL c0_101_pb: got %b want 0", put_back_to_FIFO); end
      put_word(1'b0, 3'd4);
      put_word(1'b0, 3'b110);
      checks++;
      if (put_back_to_FIFO !== 1'b1) begin errors++; $display("FAIL c1_110_pb: got %b want 1", put_back_to_FIFO); end
      put_word(1'b0, 3'b011);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL c1_011_pb: got %b want 0", put_back_to_FIFO); end
      idle_cycle();
      checks++;
      if (known !== 9'b111_011_011 || assigned !== 9'b101_010_011) begin
         errors++; $display("FAIL c1_finalize: known=%b assigned=%b want 111011011/101010011", known, assigned);
      end
      put_word(1'b0, 3'd5);
      put_word(1'b0, 3'b001);
      checks++;
      if (put_back_to_FIFO !== 1'b1) begin errors++; $display("FAIL c2_001_pb: got %b want 1", put_back_to_FIFO); end
      put_word(1'b0, 3'b100);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL c2_100_pb: got %b want 0", put_back_to_FIFO); end
      put_word(1'b0, 3'b010);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL c2_010_pb: got %b want 0", put_back_to_FIFO); end
      idle_cycle();
      checks++;
      if (known !== 9'b111_111_111 || assigned !== 9'b101_010_011 || solved !== 1'b0) begin
         errors++; $display("FAIL c2_finalize: known=%b assigned=%b solved=%b want 111111111/101010011/0", known, assigned, solved);
      end
      idle_cycle();
      checks++;
      if (solved !== 1'b1) begin errors++; $display("FAIL solved_latency: got %b want 1", solved); end
   endtask

   task automatic test_pass2();
      put_word(1'b0, 3'd0);
      put_word(1'b0, 3'b110);
      checks++;
      if (put_back_to_FIFO !== 1'b1) begin errors++; $display("FAIL p2_r0_110_pb: got %b want 1", put_back_to_FIFO); end
      put_word(1'b0, 3'b011);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL p2_r0_011_pb: got %b want 0", put_back_to_FIFO); end
      put_word(1'b0, 3'd1);
      put_word(1'b0, 3'b100);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL p2_r1_100_pb: got %b want 0", put_back_to_FIFO); end
      put_word(1'b0, 3'b010);
      checks++;
      if (put_back_to_FIFO !== 1'b1) begin errors++; $display("FAIL p2_r1_010_pb: got %b want 1", put_back_to_FIFO); end
      put_word(1'b0, 3'b001);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL p2_r1_001_pb: got %b want 0", put_back_to_FIFO); end
      // Zero-count lines: the following words are treated as further indices.
      put_word(1'b0, 3'd2);
      put_word(1'b0, 3'd3);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL p2_zero_count_pb: got %b want 0", put_back_to_FIFO); end
      put_word(1'b0, 3'd4);
      put_word(1'b0, 3'b110);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL p2_c1_single_pb: got %b want 0", put_back_to_FIFO); end
      put_word(1'b0, 3'd5);
      put_word(1'b0, 3'b001);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL p2_c2_single_pb: got %b want 0", put_back_to_FIFO); end
      idle_cycle();
      idle_cycle();
      checks++;
      if (known !== 9'b111_111_111 || assigned !== 9'b101_010_011 || solved !== 1'b1) begin
         errors++; $display("FAIL p2_final_board: known=%b assigned=%b solved=%b want 111111111/101010011/1", known, assigned, solved);
      end
      repeat (4) idle_cycle();
      checks++;
      if (solved !== 1'b1) begin errors++; $display("FAIL solved_sticky: got %b want 1", solved); end
   endtask

   task automatic test_restart();
      put_word(1'b1, 3'd2);
      idle_cycle();
      checks++;
      if (known !== 9'd0 || assigned !== 9'd0 || solved !== 1'b0) begin
         errors++; $display("FAIL restart_clear: known=%b assigned=%b solved=%b want 0/0/0", known, assigned, solved);
      end
      put_word(1'b0, 3'b101);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL restart_r2_pb: got %b want 0", put_back_to_FIFO); end
      idle_cycle();
      checks++;
      if (known !== 9'b111_000_000 || assigned !== 9'b101_000_000) begin
         errors++; $display("FAIL restart_r2_finalize: known=%b assigned=%b want 111000000/101000000", known, assigned);
      end
   endtask

   task automatic test_reset_midstream();
      put_word(1'b0, 3'd0);
      put_word(1'b0, 3'b110);
      @(negedge clk);
      valid_op = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (known !== 9'd0 || assigned !== 9'd0 || solved !== 1'b0 || put_back_to_FIFO !== 1'b0) begin
         errors++; $display("FAIL midstream_reset: known=%b assigned=%b solved=%b pb=%b want all 0", known, assigned, solved, put_back_to_FIFO);
      end
      @(negedge clk);
      rst = 1'b1;
      put_word(1'b0, 3'd0);
      put_word(1'b0, 3'b110);
      checks++;
      if (put_back_to_FIFO !== 1'b0) begin errors++; $display("FAIL idle_ignore_pb: got %b want 0", put_back_to_FIFO); end
      put_word(1'b0, 3'b011);
      idle_cycle();
      checks++;
      if (known !== 9'd0 || assigned !== 9'd0 || solved !== 1'b0) begin
         errors++; $display("FAIL idle_ignore_state: known=%b assigned=%b solved=%b want 0/0/0", known, assigned, solved);
      end
   endtask

   initial begin
      test_reset();
      test_pass1_rows();
      test_pass1_cols();
      test_pass2();
      test_restart();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
